// File: rtl/fp16_pkg.sv
// Shared types and constants for the FP16 alignment datapath.
// FRAC_W holds {hidden, man[MAN_W-1:0], guard, round}.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int MAN_W  = 10;
    localparam int FRAC_W = MAN_W + 3;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp16_t;

    typedef logic [FRAC_W-1:0] frac_t;

    // Significand with hidden bit restored; guard/round start out empty.
    // Zero and subnormal inputs have no hidden bit.
    function automatic frac_t decode_frac(input fp16_t x);
        return {(x.exp != '0), x.man, 2'b00};
    endfunction

    // Effective exponent: subnormals share the scale of exp=1.
    // Inf/NaN pass through as ordinary exp=31 values.
    function automatic logic [EXP_W-1:0] decode_exp(input fp16_t x);
        return (x.exp == '0) ? EXP_W'(1) : x.exp;
    endfunction

endpackage

// File: rtl/sticky_right_shift.sv
// Combinational right shifter with sticky collection; the right-shift
// counterpart of the leading-one normalizer.
// Sticky OR-reduce exists only when FP_ALIGN_STICKY_EN is defined;
// otherwise the sticky output is tied low.
module sticky_right_shift
    import fp16_pkg::*;
(
    input  frac_t      value,
    input  logic [4:0] amount,
    output frac_t      shifted,
    output logic       sticky
);

    // Shift the significand; any amount past the frac width flushes to zero.
    always_comb begin
        shifted = '0;
        if (amount < 5'(FRAC_W)) begin
            shifted = value >> amount;
        end
    end

`ifdef FP_ALIGN_STICKY_EN
    frac_t lost_mask;

    // Mask of the bit positions that fall off the bottom of the frac.
    always_comb begin
        lost_mask = '1;
        if (amount < 5'(FRAC_W)) begin
            lost_mask = ~({FRAC_W{1'b1}} << amount);
        end
    end

    assign sticky = |(value & lost_mask);
`else
    assign sticky = 1'b0;
`endif

endmodule

// File: rtl/fp16_align_shift.sv
// Pre-add alignment stage for the FP16 MAC adder.
// S1 picks the larger-magnitude operand and computes the exponent gap,
// S2 right-shifts the smaller significand with guard/round/sticky.
// Optional feature macro: FP_ALIGN_STICKY_EN (sticky generation).
module fp16_align_shift
    import fp16_pkg::*;
(
    input  logic             clk,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output frac_t            frac_big,
    output frac_t            frac_small,
    output logic             sticky,
    output logic [EXP_W-1:0] exp_out,
    output logic [4:0]       shift_amt,
    output logic             sign_big,
    output logic             sign_small,
    output logic             swapped
);

    // Handshake: each stage holds a valid bit; a transfer happens on a rising
    // edge where valid && ready. S2 loads when it is empty or its result is
    // being taken; S1 loads when it is empty or S2 loads. in_ready is S1's
    // load condition and so depends combinationally on out_ready.

    fp16_t            a;
    fp16_t            b;
    frac_t            frac_a;
    frac_t            frac_b;
    logic [EXP_W-1:0] eff_a;
    logic [EXP_W-1:0] eff_b;
    logic             b_bigger;

    frac_t            cmp_frac_big;
    frac_t            cmp_frac_small;
    logic [EXP_W-1:0] cmp_exp_big;
    logic [EXP_W-1:0] cmp_diff;

    logic             s1_v;
    frac_t            s1_frac_big;
    frac_t            s1_frac_small;
    logic [EXP_W-1:0] s1_exp;
    logic [EXP_W-1:0] s1_diff;
    logic             s1_sign_big;
    logic             s1_sign_small;
    logic             s1_swapped;

    logic             s2_v;
    logic             s1_load;
    logic             s2_load;

    frac_t            shifted;
    logic             shift_sticky;

    assign a = fp16_t'(op_a);
    assign b = fp16_t'(op_b);

    assign s2_load  = !s2_v || out_ready;
    assign s1_load  = !s1_v || s2_load;
    assign in_ready = s1_load;

    // Decode operands and choose the larger magnitude. Comparing the full
    // significand (hidden bit included) on equal effective exponents keeps an
    // exp=1 normal above a subnormal; ties keep A as the big operand.
    always_comb begin
        frac_a   = decode_frac(a);
        frac_b   = decode_frac(b);
        eff_a    = decode_exp(a);
        eff_b    = decode_exp(b);
        b_bigger = (eff_b > eff_a) || ((eff_b == eff_a) && (frac_b > frac_a));
        if (b_bigger) begin
            cmp_frac_big   = frac_b;
            cmp_frac_small = frac_a;
            cmp_exp_big    = eff_b;
            cmp_diff       = eff_b - eff_a;
        end else begin
            cmp_frac_big   = frac_a;
            cmp_frac_small = frac_b;
            cmp_exp_big    = eff_a;
            cmp_diff       = eff_a - eff_b;
        end
    end

    // S1 register: compare/swap results.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            s1_v          <= 1'b0;
            s1_frac_big   <= '0;
            s1_frac_small <= '0;
            s1_exp        <= '0;
            s1_diff       <= '0;
            s1_sign_big   <= 1'b0;
            s1_sign_small <= 1'b0;
            s1_swapped    <= 1'b0;
        end else if (s1_load) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_frac_big   <= cmp_frac_big;
                s1_frac_small <= cmp_frac_small;
                s1_exp        <= cmp_exp_big;
                s1_diff       <= cmp_diff;
                s1_sign_big   <= b_bigger ? b.sign : a.sign;
                s1_sign_small <= b_bigger ? a.sign : b.sign;
                s1_swapped    <= b_bigger;
            end
        end
    end

    sticky_right_shift u_shift (
        .value   (s1_frac_small),
        .amount  (s1_diff),
        .shifted (shifted),
        .sticky  (shift_sticky)
    );

    // S2 register: aligned result presented downstream; held while stalled.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            s2_v       <= 1'b0;
            frac_big   <= '0;
            frac_small <= '0;
            exp_out    <= '0;
            shift_amt  <= '0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            swapped    <= 1'b0;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                frac_big   <= s1_frac_big;
                frac_small <= shifted;
                exp_out    <= s1_exp;
                shift_amt  <= s1_diff;
                sign_big   <= s1_sign_big;
                sign_small <= s1_sign_small;
                swapped    <= s1_swapped;
            end
        end
    end

`ifdef FP_ALIGN_STICKY_EN
    // Sticky travels with the S2 result.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            sticky <= 1'b0;
        end else if (s2_load && s1_v) begin
            sticky <= shift_sticky;
        end
    end
`else
    assign sticky = 1'b0;
`endif

    assign out_valid = s2_v;

endmodule

// File: tb/tb_fp16_align_shift.sv
// Directed testbench for fp16_align_shift with hand-computed expectations.
// Honors FP_ALIGN_STICKY_EN for the expected sticky value.
module tb_fp16_align_shift;

`ifdef FP_ALIGN_STICKY_EN
    localparam bit STK_EN = 1'b1;
`else
    localparam bit STK_EN = 1'b0;
`endif

    logic        clk;
    logic        nRST;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] frac_big;
    logic [12:0] frac_small;
    logic        sticky;
    logic [4:0]  exp_out;
    logic [4:0]  shift_amt;
    logic        sign_big;
    logic        sign_small;
    logic        swapped;

    // expected word: {frac_big, frac_small, sticky, exp, shamt, sb, ss, sw}
    logic [39:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          n_acc = 0;

    fp16_align_shift dut (
        .clk        (clk),
        .nRST       (nRST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frac_big   (frac_big),
        .frac_small (frac_small),
        .sticky     (sticky),
        .exp_out    (exp_out),
        .shift_amt  (shift_amt),
        .sign_big   (sign_big),
        .sign_small (sign_small),
        .swapped    (swapped)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [39:0] pk(input logic [12:0] fb, input logic [12:0] fs,
                                       input logic stk, input logic [4:0] e,
                                       input logic [4:0] sh, input logic sb,
                                       input logic ss, input logic sw);
        return {fb, fs, stk & STK_EN, e, sh, sb, ss, sw};
    endfunction

    // driver: present a pair from posedge+1 until accepted, queue its expectation
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [39:0] e);
        int  waited;
        bit  done;
        waited   = 0;
        done     = 1'b0;
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                n_acc++;
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 50) begin
                    check("send_timeout", 40'(0), 40'(1));
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 40'(exp_q.size()), 40'(0));
    endtask

    // scoreboard: compare on transfers, check stability while stalled
    logic [39:0] held;
    bit          hold_v = 1'b0;
    always @(negedge clk) begin
        logic [39:0] got;
        logic [39:0] e;
        got = {frac_big, frac_small, sticky, exp_out, shift_amt, sign_big, sign_small, swapped};
        if (!nRST) begin
            hold_v = 1'b0;
        end else if (out_valid) begin
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 40'(1), 40'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("frac_big",   40'(frac_big),   40'(e[39:27]));
                    check("frac_small", 40'(frac_small), 40'(e[26:14]));
                    check("sticky",     40'(sticky),     40'(e[13]));
                    check("exp_out",    40'(exp_out),    40'(e[12:8]));
                    check("shift_amt",  40'(shift_amt),  40'(e[7:3]));
                    check("signs_swap", 40'({sign_big, sign_small, swapped}), 40'(e[2:0]));
                end
                hold_v = 1'b0;
            end else begin
                if (hold_v) check("stall_hold", got, held);
                held   = got;
                hold_v = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST      = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 40'(out_valid), 40'(0));
        check("rst_in_ready",  40'(in_ready),  40'(1));
        check("rst_outputs",   {frac_big, frac_small, sticky, exp_out, shift_amt,
                                sign_big, sign_small, swapped}, 40'(0));
        @(negedge clk);
        nRST = 1'b1;
        @(posedge clk);
        #1;

        // basic + latency
        send(16'h3C00, 16'h3800, pk(13'h1000, 13'h0800, 0, 15, 1, 0, 0, 0));
        check("lat_after_s1", 40'(out_valid), 40'(0));
        @(posedge clk);
        #1;
        check("lat_after_s2", 40'(out_valid), 40'(1));
        drain();

        // streaming directed vectors
        send(16'h3800, 16'h3C00, pk(13'h1000, 13'h0800, 0, 15, 1,  0, 0, 1));
        send(16'h3E00, 16'h3C00, pk(13'h1800, 13'h1000, 0, 15, 0,  0, 0, 0));
        send(16'h3C00, 16'h0001, pk(13'h1000, 13'h0000, 1, 15, 14, 0, 0, 0));
        send(16'hBC00, 16'h3800, pk(13'h1000, 13'h0800, 0, 15, 1,  1, 0, 0));
        send(16'h3C00, 16'hBC00, pk(13'h1000, 13'h1000, 0, 15, 0,  0, 1, 0));
        send(16'h3C01, 16'h3C02, pk(13'h1008, 13'h1004, 0, 15, 0,  0, 0, 1));
        send(16'h4800, 16'h3C01, pk(13'h1000, 13'h0200, 1, 18, 3,  0, 0, 0));
        send(16'h4400, 16'h3C01, pk(13'h1000, 13'h0401, 0, 17, 2,  0, 0, 0));
        send(16'h7C00, 16'h0000, pk(13'h1000, 13'h0000, 0, 31, 30, 0, 0, 0));
        send(16'h0002, 16'h0001, pk(13'h0008, 13'h0004, 0, 1,  0,  0, 0, 0));
        send(16'h0400, 16'h03FF, pk(13'h1000, 13'h0FFC, 0, 1,  0,  0, 0, 0));
        drain();

        // backpressure: only two pairs fit while the output is blocked
        out_ready = 1'b0;
        n_acc     = 0;
        fork
            begin
                send(16'h3800, 16'h3C00, pk(13'h1000, 13'h0800, 0, 15, 1, 0, 0, 1));
                send(16'h4800, 16'h3C01, pk(13'h1000, 13'h0200, 1, 18, 3, 0, 0, 0));
                send(16'h0002, 16'h0001, pk(13'h0008, 13'h0004, 0, 1,  0, 0, 0, 0));
            end
            begin
                repeat (6) @(posedge clk);
                #2;
                check("bp_accepts",  40'(n_acc),    40'(2));
                check("bp_in_ready", 40'(in_ready), 40'(0));
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_total", 40'(n_acc), 40'(3));

        // reset with two pairs in flight
        out_ready = 1'b0;
        send(16'h3C00, 16'h3800, pk(13'h1000, 13'h0800, 0, 15, 1, 0, 0, 0));
        send(16'h3E00, 16'h3C00, pk(13'h1800, 13'h1000, 0, 15, 0, 0, 0, 0));
        @(posedge clk);
        #3;
        nRST = 1'b0;
        #1;
        check("rstmid_out_valid", 40'(out_valid), 40'(0));
        check("rstmid_in_ready",  40'(in_ready),  40'(1));
        check("rstmid_frac_big",  40'(frac_big),  40'(0));
        exp_q.delete();
        @(negedge clk);
        nRST      = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rel_in_ready", 40'(in_ready), 40'(1));
        repeat (5) @(posedge clk);
        #1;
        check("rel_no_stale", 40'(out_valid), 40'(0));

        // pipeline usable again after reset
        send(16'hBC00, 16'h3800, pk(13'h1000, 13'h0800, 0, 15, 1, 1, 0, 0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
